// File: rtl/ml_pkg.sv
// rtl/ml_pkg.sv - shared defaults and state encoding for the logit collector
package ml_pkg;

    localparam int ML_N      = 8;
    localparam int ML_DATA_W = 32;
    localparam int ML_IDX_W  = $clog2(ML_N);

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_HOLD = 1'b1
    } coll_state_e;

endpackage

// File: rtl/logit_collector.sv
// rtl/logit_collector.sv - gathers one frame of logits and reports the running argmax
module logit_collector
    import ml_pkg::*;
#(
    parameter int N      = ML_N,
    parameter int DATA_W = ML_DATA_W,
    parameter int IDX_W  = ML_IDX_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  in_valid,
    input  logic [DATA_W-1:0]     in_data,
    output logic                  in_ready,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [N*DATA_W-1:0]   out_vec,
    output logic [IDX_W-1:0]      max_index,
    output logic [DATA_W-1:0]     max_value
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    coll_state_e          state_q, state_d;
    logic [IDX_W-1:0]     cnt_q, cnt_d;
    logic [N*DATA_W-1:0]  vec_q, vec_d;
    logic [IDX_W-1:0]     max_idx_q, max_idx_d;
    logic [DATA_W-1:0]    max_val_q, max_val_d;
    logic                 accept;

    // Handshakes are decoded straight from the registered state, so both are glitch-free flop outputs.
    assign in_ready  = (state_q == ST_FILL);
    assign out_valid = (state_q == ST_HOLD);
    assign out_vec   = vec_q;
    assign max_index = max_idx_q;
    assign max_value = max_val_q;

    // An accept can only happen in FILL; clear overrides it below.
    assign accept = in_valid && (state_q == ST_FILL);

    // Next-state: clear discards everything, otherwise write the slot and fold it into the running max.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        vec_d     = vec_q;
        max_idx_d = max_idx_q;
        max_val_d = max_val_q;
        if (clear) begin
            state_d   = ST_FILL;
            cnt_d     = '0;
            vec_d     = '0;
            max_idx_d = '0;
            max_val_d = '0;
        end else if (accept) begin
            vec_d[cnt_q*DATA_W +: DATA_W] = in_data;
            // Slot 0 seeds the max; later slots win only when strictly larger so ties keep the lower index.
            if (cnt_q == '0) begin
                max_val_d = in_data;
                max_idx_d = '0;
            end else if (in_data > max_val_q) begin
                max_val_d = in_data;
                max_idx_d = cnt_q;
            end
            if (cnt_q == LAST_IDX) begin
                state_d = ST_HOLD;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if ((state_q == ST_HOLD) && out_ready) begin
            state_d = ST_FILL;
        end
    end

    // State and datapath registers; reset drops any partial or held frame immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_FILL;
            cnt_q     <= '0;
            vec_q     <= '0;
            max_idx_q <= '0;
            max_val_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            vec_q     <= vec_d;
            max_idx_q <= max_idx_d;
            max_val_q <= max_val_d;
        end
    end

endmodule

// File: tb/tb_logit_collector.sv
// tb/tb_logit_collector.sv - scoreboard bench for logit_collector
module tb_logit_collector;

    localparam int N  = 8;
    localparam int DW = 32;
    localparam int IW = 3;

    typedef struct {
        logic [N*DW-1:0] vec;
        logic [IW-1:0]   idx;
        logic [DW-1:0]   val;
    } exp_t;

    logic            clk;
    logic            rst_n;
    logic            clear;
    logic            in_valid;
    logic [DW-1:0]   in_data;
    logic            in_ready;
    logic            out_valid;
    logic            out_ready;
    logic [N*DW-1:0] out_vec;
    logic [IW-1:0]   max_index;
    logic [DW-1:0]   max_value;

    int checks;
    int errors;
    exp_t sb[$];
    logic [DW-1:0] frame_buf [N];

    logit_collector #(.N(N), .DATA_W(DW), .IDX_W(IW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_vec   (out_vec),
        .max_index (max_index),
        .max_value (max_value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive frame_buf into the DUT with up to max_gap idle cycles before each logit; push the expected result.
    task automatic feed_frame(input int max_gap, input bit push);
        exp_t e;
        e.vec = '0;
        e.idx = '0;
        e.val = '0;
        for (int j = 0; j < N; j++) begin
            e.vec[j*DW +: DW] = frame_buf[j];
            if (j == 0 || frame_buf[j] > e.val) begin
                e.val = frame_buf[j];
                e.idx = IW'(j);
            end
        end
        if (push) sb.push_back(e);
        for (int j = 0; j < N; j++) begin
            int gap;
            gap = (max_gap > 0) ? $urandom_range(max_gap, 0) : 0;
            repeat (gap) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
            in_valid = 1'b1;
            in_data  = frame_buf[j];
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output bit ok);
        int n;
        n = 0;
        while (!out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        ok = out_valid;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || max_index !== '0 || max_value !== '0 || out_vec !== '0) begin
            errors++;
            $display("FAIL reset_state: valid=%b ready=%b idx=%0d val=%h vec_nonzero=%b required valid=0 ready=1 idx=0 val=0 vec=0",
                     out_valid, in_ready, max_index, max_value, |out_vec);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic [DW-1:0] d [N] = '{5, 9, 3, 9, 1, 0, 7, 2};
        frame_buf = d;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle_valid: out_valid=%b required 0", out_valid);
        end
        feed_frame(0, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_latency: out_valid=%b in_ready=%b required 1 0 one cycle after last accept", out_valid, in_ready);
        end
        e = sb.pop_front();
        checks++;
        if (max_index !== e.idx || max_value !== e.val || out_vec !== e.vec) begin
            errors++;
            $display("FAIL b2b_result: idx=%0d val=%0d required idx=%0d val=%0d vec_ok=%b",
                     max_index, max_value, e.idx, e.val, out_vec === e.vec);
        end
        checks++;
        if (e.idx !== 3'd1 || e.val !== 32'd9) begin
            errors++;
            $display("FAIL b2b_model: model idx=%0d val=%0d required 1 9", e.idx, e.val);
        end
        handshake();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_release: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_unsigned();
        exp_t e;
        bit ok;
        logic [DW-1:0] d [N] = '{32'h8000_0000, 32'h7FFF_FFFF, 0, 0, 0, 0, 0, 0};
        frame_buf = d;
        feed_frame(2, 1'b1);
        wait_out(ok);
        e = sb.pop_front();
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL unsigned_timeout: out_valid=%b required 1", out_valid);
        end
        checks++;
        if (max_index !== 3'd0 || max_value !== 32'h8000_0000 || max_value !== e.val || out_vec !== e.vec) begin
            errors++;
            $display("FAIL unsigned_result: idx=%0d val=%h required idx=0 val=80000000", max_index, max_value);
        end
        handshake();
    endtask

    task automatic test_hold_stall();
        exp_t e;
        bit ok;
        for (int j = 0; j < N; j++) frame_buf[j] = $urandom;
        feed_frame(1, 1'b1);
        wait_out(ok);
        e = sb.pop_front();
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL stall_timeout: out_valid=%b required 1", out_valid);
        end
        for (int c = 0; c < 10; c++) begin
            in_valid = 1'b1;
            in_data  = $urandom;
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_vec !== e.vec || max_index !== e.idx || max_value !== e.val) begin
                errors++;
                $display("FAIL stall_stable cycle %0d: ready=%b valid=%b idx=%0d val=%h required ready=0 valid=1 idx=%0d val=%h vec_ok=%b",
                         c, in_ready, out_valid, max_index, max_value, e.idx, e.val, out_vec === e.vec);
            end
        end
        in_valid = 1'b0;
        handshake();
    endtask

    task automatic test_clear();
        exp_t e;
        bit ok;
        for (int j = 0; j < 4; j++) begin
            in_valid = 1'b1;
            in_data  = 32'd100 + 32'(j);
            @(negedge clk);
        end
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'd999;
        @(negedge clk);
        clear    = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || max_value !== '0) begin
            errors++;
            $display("FAIL clear_state: valid=%b ready=%b val=%0d required 0 1 0", out_valid, in_ready, max_value);
        end
        for (int j = 0; j < N; j++) frame_buf[j] = 32'(j + 1);
        feed_frame(0, 1'b1);
        wait_out(ok);
        e = sb.pop_front();
        checks++;
        if (!ok || max_index !== 3'd7 || max_value !== 32'd8 || out_vec !== e.vec) begin
            errors++;
            $display("FAIL clear_result: ok=%b idx=%0d val=%0d required idx=7 val=8 vec_ok=%b",
                     ok, max_index, max_value, out_vec === e.vec);
        end
        handshake();
    endtask

    task automatic test_reset_mid();
        exp_t e;
        bit ok;
        for (int j = 0; j < 5; j++) begin
            in_valid = 1'b1;
            in_data  = 32'd500 + 32'(j);
            @(negedge clk);
        end
        in_data = 32'hFFFF_FFFF;
        rst_n   = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || max_index !== '0 || max_value !== '0 || out_vec !== '0) begin
            errors++;
            $display("FAIL midreset_state: valid=%b ready=%b idx=%0d val=%h vec_nonzero=%b required 0 1 0 0 0",
                     out_valid, in_ready, max_index, max_value, |out_vec);
        end
        rst_n = 1'b1;
        @(negedge clk);
        for (int j = 0; j < N; j++) frame_buf[j] = 32'd50 - 32'(j * 3);
        feed_frame(0, 1'b1);
        wait_out(ok);
        e = sb.pop_front();
        checks++;
        if (!ok || max_index !== e.idx || max_value !== e.val || out_vec !== e.vec || max_value !== 32'd50) begin
            errors++;
            $display("FAIL midreset_result: ok=%b idx=%0d val=%0d required idx=%0d val=%0d", ok, max_index, max_value, e.idx, e.val);
        end
        handshake();
    endtask

    task automatic test_random();
        exp_t e;
        bit ok;
        for (int f = 0; f < 100; f++) begin
            for (int j = 0; j < N; j++) begin
                frame_buf[j] = ($urandom_range(3, 0) == 0) ? 32'($urandom_range(4, 0)) : $urandom;
            end
            feed_frame(3, 1'b1);
            wait_out(ok);
            e = sb.pop_front();
            checks++;
            if (!ok || max_index !== e.idx || max_value !== e.val || out_vec !== e.vec) begin
                errors++;
                $display("FAIL random_frame %0d: ok=%b idx=%0d val=%h required idx=%0d val=%h vec_ok=%b",
                         f, ok, max_index, max_value, e.idx, e.val, out_vec === e.vec);
            end
            repeat ($urandom_range(3, 0)) @(negedge clk);
            handshake();
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_back_to_back();
        test_unsigned();
        test_hold_stall();
        test_clear();
        test_reset_mid();
        test_random();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/logit_collector.md
LOGIT_COLLECTOR -- requirements
Module: logit_collector

Interface
REQ-001 Parameter N, default 8: logits per frame.
REQ-002 Parameter DATA_W, default 32: logit width, unsigned.
REQ-003 Parameter IDX_W, default 3: index width, equal to clog2(N).
REQ-004 Clock/reset: one clock `clk`; reset `rst_n` is asynchronous and active-low.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 clear  input  1  synchronous frame abort.
REQ-008 in_valid  input  1  logit present on in_data.
REQ-009 in_data  input  DATA_W  logit, in frame order (index 0 first).
REQ-010 in_ready  output  1  collector accepts a logit this cycle.
REQ-011 out_valid  output  1  complete frame and result held.
REQ-012 out_ready  input  1  consumer takes the result.
REQ-013 out_vec  output  N*DATA_W  stored frame; element k at bits [k*DATA_W +: DATA_W].
REQ-014 max_index  output  IDX_W  index of the largest logit.
REQ-015 max_value  output  DATA_W  largest logit.

Function
REQ-016 Two states: FILL and HOLD.
REQ-017 In FILL, in_ready=1 and out_valid=0; in HOLD, in_ready=0 and out_valid=1.
REQ-018 A logit is accepted on a rising edge with in_valid=1 and in_ready=1; it is written to slot cnt; cnt then increments.
REQ-019 On accept at cnt=0: max_value<=in_data and max_index<=0 unconditionally.
REQ-020 On accept at cnt>0: update max_value/max_index only if in_data > max_value (unsigned, strict).
REQ-021 Ties keep the lowest index.
REQ-022 Accept at cnt=N-1: the next state is HOLD and cnt returns to 0.
REQ-023 out_valid rises the cycle after the last logit is accepted (latency 1).
REQ-024 In HOLD, out_vec/max_index/max_value remain stable until the handshake completes.
REQ-025 In HOLD, out_ready=1 returns the block to FILL on the next edge.
REQ-026 After HOLD the block spends one FILL cycle minimum before the next frame can complete; there is no accept in a cycle with out_valid=1.
REQ-027 in_valid while in HOLD is ignored; the data is not stored.
REQ-028 clear=1 in any state: the next state is FILL, cnt becomes 0, and any partial frame or held result is discarded.
REQ-029 clear wins over a simultaneous accept or out handshake.
REQ-030 cnt is not advanced by any cycle with in_valid=0.

Reset
REQ-031 rst_n low: state=FILL, cnt=0, out_valid=0, in_ready=1 once released, max_index=0, max_value=0, out_vec all zero.
REQ-032 rst_n asserted mid-frame or in HOLD aborts the frame immediately; no partial result survives.

Structure
REQ-033 The shared package ml_pkg holds DATA_W, N, and IDX_W defaults, plus the FILL/HOLD state enum.
REQ-034 The block is single-module with no sub-module; the compare/update is inline with the slot write.

Verification
REQ-035 Feed 8 logits 5,9,3,9,1,0,7,2 back-to-back, then out_ready=1 -> out_valid 1 cycle after the 8th; max_index=1, max_value=9.
REQ-036 Feed 0x80000000 then 0x7FFFFFFF then six zeros -> max_index=0, max_value=0x80000000 (unsigned compare).
REQ-037 Feed a full frame, hold out_ready=0 for 10 cycles while in_valid=1 -> in_ready stays 0 and outputs are stable; no logits are stored.
REQ-038 Feed 4 logits, pulse clear together with in_valid, then feed 8 logits of 1..8 -> max_index=7, max_value=8, and out_vec contains only the new frame.
REQ-039 Assert rst_n low during accept of the 6th logit -> all outputs return to reset values; the next full frame is reported correctly.
REQ-040 Feed random in_valid gaps across 100 frames -> max_index/max_value match a software argmax in every frame.
